spi_eeprom_responder: RTL and testbench
=======================================

// Module: spi_eeprom_responder
// PURPOSE
// SPI mode-0 responder emulating a 25-series serial EEPROM. It is the far end of the
// core's SPI program-fetch master. Used on-die as a selectable internal program store,
// and in benches as the memory model behind the SPI pins.
// Backed by an internal byte array. A back-door load port lets firmware images be
// preloaded without SPI traffic.
// PARAMETERS
// DEPTH       64  bytes of storage; power of two, 2..256
// ADDR_BYTES  1   address bytes following READ/WRITE opcode (1 or 2)
// PORTS
// clk          in   1  system clock; must be >= 8x spi_sck frequency
// rst_n        in   1  asynchronous active-low reset
// spi_cs_n     in   1  chip select, active low, asynchronous to clk
// spi_sck      in   1  SPI clock, idle low (mode 0), asynchronous to clk
// spi_mosi     in   1  data from master, MSB first
// spi_miso     out  1  data to master, MSB first
// spi_miso_oe  out  1  1 = drive spi_miso; 0 = release
// busy         out  1  1 while a synchronised transaction is in progress (CS low)
// wel          out  1  write-enable latch, mirrors status bit 1
// ld_valid     in   1  back-door write strobe, one byte per cycle
// ld_addr      in   8  back-door address; uses low log2(DEPTH) bits
// ld_data      in   8  back-door data
// BEHAVIOUR
// - Reset: spi_miso=0, spi_miso_oe=0, busy=0, wel=0, state IDLE, shift regs 0.
//   Memory contents are not reset.
// - Synchronisation: cs_n, sck and mosi pass through 2-flop synchronisers.
//   SCK rise/fall are edge-detected in the clk domain.
//   spi_miso is updated <=3 clk after a raw SCK falling edge.
// - Sampling: MOSI is sampled on SCK rise; MISO shifts on SCK fall.
//   Bit counter 0..7; a byte is complete on the 8th rise.
// - CS rising (sync) at any time -> state IDLE, bit counter cleared,
//   spi_miso_oe=0, busy=0. A partial byte is discarded, never written.
// - FSM states: IDLE, CMD, ADDR, READ, WRITE, STATUS, IGNORE.
//   IDLE -> CMD on CS falling.
//   CMD: on byte complete, dispatch the opcode:
//     0x03 READ  -> ADDR
//     0x02 WRITE -> ADDR
//     0x06 WREN  -> set wel, then IGNORE
//     0x04 WRDI  -> clear wel, then IGNORE
//     0x05 RDSR  -> STATUS
//     any other opcode -> IGNORE
//   ADDR: ADDR_BYTES bytes, MSB first. Address = value mod DEPTH.
//     On the last address byte, go to READ or WRITE per the latched opcode.
//   READ: load mem[addr] into the shift register on the SCK fall after the last
//     address bit, and drive bit7 with spi_miso_oe=1. After each 8 data bits,
//     addr increments, load the next byte on that fall. Runs until CS high.
//   WRITE: each completed data byte -> if wel, mem[addr]<=byte; addr increments.
//     If wel=0 the byte is discarded.
//   STATUS: shifts {6'b0, wel, 1'b0} repeatedly (WIP always 0), spi_miso_oe=1.
//   IGNORE: MOSI is ignored and spi_miso_oe=0 until CS high.
// - wel clears on CS rising when the ended transaction was WRITE and had >=1
//   complete data byte. WRITE with no data bytes leaves wel set.
// - Address wrap: DEPTH-1 increments to 0 for both READ and WRITE.
// - Back-door: ld_valid writes mem[ld_addr] in the same cycle regardless of busy.
//   If an SPI write commits the same cycle, the SPI write wins.
//   A back-door write is visible to any byte loaded for READ afterwards.
// - spi_miso holds its last value when spi_miso_oe=0. Outputs are registered.
// TESTING
// - Preload mem[0x10..0x12]=A5,3C,FF via ld; READ 03 10, 24 SCKs -> MISO bytes A5,3C,FF.
// - WRITE 02 05 77 without WREN -> mem[5] unchanged. Then WREN 06, WRITE 02 05 77
//   -> mem[5]=77 and wel=0 after CS high.
// - RDSR 05 after WREN -> MISO 0x02; after WRDI 04 -> 0x00.
// - READ at address DEPTH-1 (0x3F) for 2 bytes -> mem[0x3F] then mem[0x00] (wrap).
// - WRITE with CS raised after 5 data bits -> no memory change, busy=0,
//   state IDLE; the next READ works.
// - Assert rst_n low mid-READ -> spi_miso_oe=0 and busy=0 immediately.
//   Memory retains its contents.

Source files
------------

// File: rtl/spi_eeprom_responder.sv
// spi_eeprom_responder: SPI mode-0 responder emulating a 25-series EEPROM over an internal byte array
// with a back-door load port; all SPI pins are synchronised into the clk domain.
module spi_eeprom_responder #(
    parameter int DEPTH      = 64,
    parameter int ADDR_BYTES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_cs_n,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       busy,
    output logic       wel,
    input  logic       ld_valid,
    input  logic [7:0] ld_addr,
    input  logic [7:0] ld_data
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, STATUS, IGNORE} state_t;
    state_t state, state_d;

    logic [2:0]    cs_s, sck_s;
    logic [1:0]    mosi_s;
    logic [2:0]    bit_cnt;
    logic [7:0]    rx, tx;
    logic [AW-1:0] addr;
    logic          addr_cnt, op_write, wrote;
    logic [7:0]    mem [DEPTH];

    logic       cs_fall, cs_rise, sck_rise, sck_fall, byte_done, addr_last, load, spi_we;
    logic [7:0] rx_byte, load_byte;

    assign cs_fall   = cs_s[2] & ~cs_s[1];
    assign cs_rise   = ~cs_s[2] & cs_s[1];
    assign sck_rise  = ~sck_s[2] & sck_s[1];
    assign sck_fall  = sck_s[2] & ~sck_s[1];
    assign rx_byte   = {rx[6:0], mosi_s[1]};
    assign byte_done = (state != IDLE) && !cs_rise && !cs_fall && sck_rise && bit_cnt == 3'd7;
    assign addr_last = ADDR_BYTES == 1 || addr_cnt;
    // First fall of each data byte: reload the shifter (READ post-increments addr here)
    assign load      = (state == READ || state == STATUS) && !cs_rise && sck_fall && bit_cnt == 3'd0;
    assign load_byte = state == READ ? mem[addr] : {6'b0, wel, 1'b0};
    assign spi_we    = state == WRITE && byte_done && wel;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_d;

    always_comb begin
        state_d = state;
        if (cs_rise)
            state_d = IDLE;
        else if (cs_fall)
            state_d = CMD;
        else if (byte_done && state == CMD)
            state_d = rx_byte == 8'h03 || rx_byte == 8'h02 ? ADDR :
                      rx_byte == 8'h05 ? STATUS : IGNORE;
        else if (byte_done && state == ADDR && addr_last)
            state_d = op_write ? WRITE : READ;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_s <= 3'b111;
            sck_s <= '0;
            mosi_s <= '0;
            bit_cnt <= '0;
            rx <= '0;
            tx <= '0;
            addr <= '0;
            addr_cnt <= 1'b0;
            op_write <= 1'b0;
            wrote <= 1'b0;
            spi_miso <= 1'b0;
            spi_miso_oe <= 1'b0;
            busy <= 1'b0;
            wel <= 1'b0;
        end else begin
            cs_s <= {cs_s[1:0], spi_cs_n};
            sck_s <= {sck_s[1:0], spi_sck};
            mosi_s <= {mosi_s[0], spi_mosi};
            if (cs_rise) begin
                bit_cnt <= '0;
                spi_miso_oe <= 1'b0;
                busy <= 1'b0;
                if (state == WRITE && wrote) wel <= 1'b0;
            end else if (cs_fall) begin
                bit_cnt <= '0;
                rx <= '0;
                busy <= 1'b1;
                addr_cnt <= 1'b0;
                wrote <= 1'b0;
            end else if (state != IDLE) begin
                if (sck_rise) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    rx <= rx_byte;
                end
                if (byte_done && state == CMD) begin
                    op_write <= rx_byte == 8'h02;
                    wel <= rx_byte == 8'h06 ? 1'b1 : rx_byte == 8'h04 ? 1'b0 : wel;
                end
                if (byte_done && state == ADDR) begin
                    addr <= AW'(rx_byte);
                    addr_cnt <= ~addr_cnt;
                end
                if (byte_done && state == WRITE) begin
                    addr <= addr + 1'b1;
                    wrote <= 1'b1;
                end
                if (load) begin
                    tx <= load_byte;
                    spi_miso <= load_byte[7];
                    spi_miso_oe <= 1'b1;
                    if (state == READ) addr <= addr + 1'b1;
                end else if (sck_fall && spi_miso_oe) begin
                    tx <= {tx[6:0], 1'b0};
                    spi_miso <= tx[6];
                end
            end
        end
    end

    // SPI commit takes priority over a simultaneous back-door load
    always_ff @(posedge clk)
        if (spi_we)        mem[addr] <= rx_byte;
        else if (ld_valid) mem[AW'(ld_addr)] <= ld_data;
endmodule

// File: tb/tb_spi_eeprom_responder.sv
// tb_spi_eeprom_responder: drives SPI transactions against a byte-array model; expected
// MISO bytes are queued at stimulus time and popped as each response byte arrives.
module tb_spi_eeprom_responder;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       spi_cs_n = 1'b1, spi_sck = 1'b0, spi_mosi = 1'b0;
    logic       spi_miso, spi_miso_oe, busy, wel;
    logic       ld_valid = 1'b0;
    logic [7:0] ld_addr = '0, ld_data = '0;

    spi_eeprom_responder dut (
        .clk(clk), .rst_n(rst_n), .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .busy(busy), .wel(wel),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    int         n_chk = 0, n_pass = 0;
    logic [7:0] mdl [64];
    logic       wel_m = 1'b0;
    logic [7:0] exp_q [$];
    logic [7:0] r;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic ld(input logic [7:0] a, input logic [7:0] d);
        ld_valid = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        mdl[a[5:0]] = d;
    endtask

    task automatic xfer(input logic [7:0] t, input int nb, output logic [7:0] rd);
        rd = '0;
        for (int i = 0; i < nb; i++) begin
            spi_mosi = t[7-i];
            #50;
            rd = {rd[6:0], spi_miso};
            spi_sck = 1'b1;
            #50;
            spi_sck = 1'b0;
        end
    endtask

    task automatic cs_low;
        spi_cs_n = 1'b0; #50;
    endtask

    task automatic cs_high;
        #50; spi_cs_n = 1'b1; #100;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] got);
        if (exp_q.size() == 0) chk({tag, "_underflow"}, 1, 0);
        else chk(tag, got, exp_q.pop_front());
    endtask

    task automatic cmd1(input logic [7:0] op);
        cs_low; xfer(op, 8, r); cs_high;
        if (op == 8'h06) wel_m = 1'b1;
        if (op == 8'h04) wel_m = 1'b0;
    endtask

    task automatic spi_read(input logic [7:0] a, input int n);
        cs_low; xfer(8'h03, 8, r); xfer(a, 8, r);
        chk("busy_rd", busy, 1);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mdl[6'(a + 8'(i))]);
            xfer(8'h00, 8, r);
            pop_chk("rd_byte", r);
        end
        chk("oe_rd", spi_miso_oe, 1);
        cs_high;
        chk("oe_end", spi_miso_oe, 0);
        chk("busy_end", busy, 0);
    endtask

    task automatic spi_write(input logic [7:0] a, input int n, input logic [7:0] d0, input logic [7:0] d1);
        cs_low; xfer(8'h02, 8, r); xfer(a, 8, r);
        for (int i = 0; i < n; i++) begin
            xfer(i == 0 ? d0 : d1, 8, r);
            if (wel_m) mdl[6'(a + 8'(i))] = i == 0 ? d0 : d1;
        end
        cs_high;
        if (n > 0) wel_m = 1'b0;
        chk("wel_wr", wel, 32'(wel_m));
    endtask

    task automatic rdsr(input int n);
        cs_low; xfer(8'h05, 8, r);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({6'b0, wel_m, 1'b0});
            xfer(8'h00, 8, r);
            pop_chk("rdsr", r);
        end
        cs_high;
    endtask

    initial begin
        #23;
        chk("rst_miso", spi_miso, 0);
        chk("rst_oe", spi_miso_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wel", wel, 0);
        rst_n = 1'b1;
        #40;
        for (int i = 0; i < 64; i++) ld(8'(i), 8'(i * 7 + 1));
        ld(8'h10, 8'hA5); ld(8'h11, 8'h3C); ld(8'h12, 8'hFF);
        ld(8'h3F, 8'h5A); ld(8'h00, 8'hC3);
        spi_read(8'h10, 3);
        spi_write(8'h05, 1, 8'h77, 8'h00);
        spi_read(8'h05, 1);
        cmd1(8'h06);
        chk("wel_set", wel, 1);
        rdsr(2);
        spi_write(8'h05, 1, 8'h77, 8'h00);
        spi_read(8'h05, 1);
        cmd1(8'h06); cmd1(8'h04);
        chk("wel_clr", wel, 0);
        rdsr(1);
        spi_read(8'h3F, 2);
        spi_read(8'hBF, 1);
        cmd1(8'h06);
        spi_write(8'h3F, 2, 8'h12, 8'h34);
        spi_read(8'h3E, 3);
        cmd1(8'h06);
        cs_low; xfer(8'h02, 8, r); xfer(8'h07, 8, r); xfer(8'hEE, 5, r); cs_high;
        chk("part_busy", busy, 0);
        chk("part_wel", wel, 1);
        spi_read(8'h07, 1);
        spi_write(8'h08, 0, 8'h00, 8'h00);
        chk("nodata_wel", wel, 1);
        cmd1(8'h04);
        cs_low; xfer(8'h03, 8, r); xfer(8'h20, 8, r);
        exp_q.push_back(mdl[8'h20]);
        xfer(8'h00, 8, r);
        pop_chk("bd_rd0", r);
        ld(8'h22, 8'h99);
        for (int i = 1; i < 3; i++) begin
            exp_q.push_back(mdl[8'h20 + i]);
            xfer(8'h00, 8, r);
            pop_chk("bd_rd", r);
        end
        cs_high;
        cmd1(8'h9F);
        chk("ign_oe", spi_miso_oe, 0);
        cs_low; xfer(8'h03, 8, r); xfer(8'h10, 8, r); xfer(8'h00, 3, r);
        rst_n = 1'b0;
        #1;
        chk("rstmid_oe", spi_miso_oe, 0);
        chk("rstmid_busy", busy, 0);
        spi_cs_n = 1'b1; #100;
        rst_n = 1'b1; #40;
        wel_m = 1'b0;
        spi_read(8'h10, 3);
        chk("q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
